// File: rtl/chkmon_pkg.sv
// ==========================================================================
// chkmon_pkg : shared state encoding and default markers for the monitor
// Rev 1.0
// ==========================================================================
`default_nettype none

package chkmon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } chkmon_state_e;

    localparam logic [15:0] DEF_ARM_MARK   = 16'hAB40;
    localparam logic [15:0] DEF_START_MARK = 16'h00A5;
    localparam logic [15:0] DEF_END_MARK   = 16'h765A;
    localparam int          DEF_TIMEOUT    = 250000;

endpackage

`default_nettype wire

// File: rtl/checkbits_round_monitor_if.sv
// ==========================================================================
// checkbits_round_monitor_if : checkbits input and round status bundle
// CHKMON_GOLDEN_CMP_EN adds the golden-compare handshake. Rev 1.0
// ==========================================================================
`default_nettype none

interface checkbits_round_monitor_if #(
    parameter int CB_W   = 16,
    parameter int CNT_W  = 32,
    parameter int ROUNDS = 3
) ();
    localparam int IDX_W = $clog2(ROUNDS + 1);

    logic [CB_W-1:0]  checkbits;
    logic             clr;
    logic             busy;
    logic             round_done;
    logic [IDX_W-1:0] round_idx;
    logic [CNT_W-1:0] latency;
    logic             lat_sat;
    logic             all_done;
    logic             timeout;
`ifdef CHKMON_GOLDEN_CMP_EN
    logic [CB_W-1:0]  gold_data;
    logic             gold_valid;
    logic             gold_ready;
    logic [7:0]       match_cnt;

    modport master (
        output checkbits, clr, gold_data, gold_valid,
        input  busy, round_done, round_idx, latency, lat_sat, all_done, timeout,
               gold_ready, match_cnt
    );
    modport slave (
        input  checkbits, clr, gold_data, gold_valid,
        output busy, round_done, round_idx, latency, lat_sat, all_done, timeout,
               gold_ready, match_cnt
    );
`else
    modport master (
        output checkbits, clr,
        input  busy, round_done, round_idx, latency, lat_sat, all_done, timeout
    );
    modport slave (
        input  checkbits, clr,
        output busy, round_done, round_idx, latency, lat_sat, all_done, timeout
    );
`endif

endinterface

`default_nettype wire

// File: rtl/checkbits_golden_cmp.sv
// ==========================================================================
// checkbits_golden_cmp : in-order match of registered checkbits vs golden y
// Built only with CHKMON_GOLDEN_CMP_EN. Rev 1.0
// ==========================================================================
`default_nettype none

`ifdef CHKMON_GOLDEN_CMP_EN
module checkbits_golden_cmp #(
    parameter int CB_W = 16
) (
    input  logic            clock,
    input  logic            resetb,
    input  logic            clr,
    input  logic            run,
    input  logic            enter_run,
    input  logic [CB_W-1:0] cb_q,
    input  logic [CB_W-1:0] gold_data,
    input  logic            gold_valid,
    output logic            gold_ready,
    output logic [7:0]      match_cnt
);
    logic [7:0] r_match_cnt;
    logic       w_match;

    // The consumer advances its golden pointer on each strobe, so ordering is implicit.
    assign w_match    = run && gold_valid && (cb_q == gold_data);
    assign gold_ready = w_match;
    assign match_cnt  = r_match_cnt;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_match_cnt <= 8'd0;
        end else if (clr || enter_run) begin
            r_match_cnt <= 8'd0;
        end else if (w_match && (r_match_cnt != 8'hFF)) begin
            r_match_cnt <= r_match_cnt + 8'd1;
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/checkbits_round_monitor.sv
// ==========================================================================
// checkbits_round_monitor : FIR round detector and latency/timeout monitor
// Option macro: CHKMON_GOLDEN_CMP_EN (golden y compare). Rev 1.0
// ==========================================================================
`default_nettype none

module checkbits_round_monitor
    import chkmon_pkg::*;
#(
    parameter int            CB_W       = 16,
    parameter int            CNT_W      = 32,
    parameter int            ROUNDS     = 3,
    parameter logic [CB_W-1:0] ARM_MARK   = CB_W'(DEF_ARM_MARK),
    parameter logic [CB_W-1:0] START_MARK = CB_W'(DEF_START_MARK),
    parameter logic [CB_W-1:0] END_MARK   = CB_W'(DEF_END_MARK),
    parameter int            TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                      clock,
    input  logic                      resetb,
    checkbits_round_monitor_if.slave  mon
);
    localparam int IDX_W = $clog2(ROUNDS + 1);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

    chkmon_state_e    r_state;
    chkmon_state_e    w_state_nxt;
    logic [CB_W-1:0]  r_cb_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_latency;
    logic             r_lat_sat;
    logic             r_round_done;
    logic [IDX_W-1:0] r_round_idx;
    logic             r_all_done;
    logic             r_timeout;
    logic [TMO_W-1:0] r_tcnt;

    logic w_tmo_hit;
    logic w_start_hit;
    logic w_end_hit;
    logic w_last_round;
    logic w_in_run;

    // Fires on the edge that brings the free-running counter to TIMEOUT.
    assign w_tmo_hit = (TIMEOUT != 0) && (r_tcnt == TMO_LAST) && !r_all_done && !r_timeout;
    assign w_in_run  = (r_state == ST_RUN);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_hit  = 1'b0;
        w_end_hit    = 1'b0;
        w_last_round = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_cb_q == ARM_MARK) begin
                    w_state_nxt = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (r_cb_q == START_MARK) begin
                    w_state_nxt = ST_RUN;
                    w_start_hit = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_cb_q == END_MARK) begin
                    w_end_hit = 1'b1;
                    if (r_round_idx == IDX_LAST) begin
                        w_last_round = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end else begin
                        w_state_nxt  = ST_WAIT_START;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // clr outranks timeout, which outranks a coincident END.
        if (w_tmo_hit) begin
            w_state_nxt  = ST_DONE;
            w_start_hit  = 1'b0;
            w_end_hit    = 1'b0;
            w_last_round = 1'b0;
        end
        if (mon.clr) begin
            w_state_nxt  = ST_IDLE;
            w_start_hit  = 1'b0;
            w_end_hit    = 1'b0;
            w_last_round = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_cb_q       <= '0;
            r_cnt        <= '0;
            r_latency    <= '0;
            r_lat_sat    <= 1'b0;
            r_round_done <= 1'b0;
            r_round_idx  <= '0;
            r_all_done   <= 1'b0;
            r_timeout    <= 1'b0;
            r_tcnt       <= '0;
        end else if (mon.clr) begin
            r_cb_q       <= '0;
            r_cnt        <= '0;
            r_latency    <= '0;
            r_lat_sat    <= 1'b0;
            r_round_done <= 1'b0;
            r_round_idx  <= '0;
            r_all_done   <= 1'b0;
            r_timeout    <= 1'b0;
            r_tcnt       <= '0;
        end else begin
            r_cb_q       <= mon.checkbits;
            r_round_done <= w_end_hit;
            if (r_tcnt != TMO_MAX) begin
                r_tcnt <= r_tcnt + TMO_W'(1);
            end
            if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
            if (w_start_hit) begin
                r_cnt <= CNT_W'(1);
            end else if (w_in_run && !w_end_hit && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_end_hit) begin
                r_latency   <= r_cnt;
                r_lat_sat   <= &r_cnt;
                r_round_idx <= r_round_idx + IDX_W'(1);
            end
            if (w_last_round) begin
                r_all_done <= 1'b1;
            end
        end
    end

    assign mon.busy       = (r_state == ST_WAIT_START) || (r_state == ST_RUN);
    assign mon.round_done = r_round_done;
    assign mon.round_idx  = r_round_idx;
    assign mon.latency    = r_latency;
    assign mon.lat_sat    = r_lat_sat;
    assign mon.all_done   = r_all_done;
    assign mon.timeout    = r_timeout;

`ifdef CHKMON_GOLDEN_CMP_EN
    checkbits_golden_cmp #(
        .CB_W (CB_W)
    ) u_golden_cmp (
        .clock      (clock),
        .resetb     (resetb),
        .clr        (mon.clr),
        .run        (w_in_run),
        .enter_run  (w_start_hit),
        .cb_q       (r_cb_q),
        .gold_data  (mon.gold_data),
        .gold_valid (mon.gold_valid),
        .gold_ready (mon.gold_ready),
        .match_cnt  (mon.match_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_checkbits_round_monitor.sv
// ==========================================================================
// tb_checkbits_round_monitor : directed + random bench with timestamp model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_checkbits_round_monitor;

    localparam logic [15:0] ARM  = 16'hAB40;
    localparam logic [15:0] STA  = 16'h00A5;
    localparam logic [15:0] ENDM = 16'h765A;
    localparam int          ROUNDS = 3;
    localparam int          M_TMO  = 250000;

    logic clock = 1'b0;
    logic resetb = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    checkbits_round_monitor_if #(.CB_W(16), .CNT_W(32), .ROUNDS(ROUNDS)) mon ();
    checkbits_round_monitor_if #(.CB_W(16), .CNT_W(32), .ROUNDS(ROUNDS)) mon_t ();

    assign mon_t.checkbits = mon.checkbits;
    assign mon_t.clr       = mon.clr;
`ifdef CHKMON_GOLDEN_CMP_EN
    assign mon_t.gold_data  = 16'h0000;
    assign mon_t.gold_valid = 1'b0;
`endif

    checkbits_round_monitor #(.TIMEOUT(M_TMO)) dut (
        .clock  (clock),
        .resetb (resetb),
        .mon    (mon)
    );

    checkbits_round_monitor #(.TIMEOUT(500)) dut_t (
        .clock  (clock),
        .resetb (resetb),
        .mon    (mon_t)
    );

    // Reference: rounds as timestamps; latency is the cycle distance START->END.
    logic [15:0] m_cbq;
    bit          m_armed, m_running, m_finished, m_rd, m_all, m_tmo;
    int          m_cyc, m_start, m_rounds, m_since;
    logic [31:0] m_lat;

`ifdef CHKMON_GOLDEN_CMP_EN
    logic [15:0] gold [64];
    int          gidx;
    bit          gold_on;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cbq = 16'h0; m_armed = 0; m_running = 0; m_finished = 0;
        m_rd = 0; m_all = 0; m_tmo = 0; m_rounds = 0; m_since = 0;
        m_lat = 32'h0; m_start = 0;
    endtask

    task automatic model_edge(input logic [15:0] cb_in, input logic c);
        m_rd = 0;
        m_cyc++;
        if (c) begin
            model_clear();
            return;
        end
        m_since++;
        if (m_since == M_TMO && !m_all && !m_tmo) begin
            m_tmo = 1; m_armed = 0; m_running = 0; m_finished = 1;
        end else if (!m_finished) begin
            if (m_running) begin
                if (m_cbq == ENDM) begin
                    m_lat = 32'(m_cyc - m_start);
                    m_rd = 1;
                    m_rounds++;
                    m_running = 0;
                    if (m_rounds == ROUNDS) begin
                        m_all = 1; m_finished = 1;
                    end else begin
                        m_armed = 1;
                    end
                end
            end else if (m_armed) begin
                if (m_cbq == STA) begin
                    m_armed = 0; m_running = 1; m_start = m_cyc;
                end
            end else if (m_cbq == ARM) begin
                m_armed = 1;
            end
        end
        m_cbq = cb_in;
    endtask

    task automatic check_all();
        chk("busy",       64'(mon.busy),       64'(m_armed || m_running));
        chk("round_done", 64'(mon.round_done), 64'(m_rd));
        chk("round_idx",  64'(mon.round_idx),  64'(m_rounds));
        chk("latency",    64'(mon.latency),    64'(m_lat));
        chk("lat_sat",    64'(mon.lat_sat),    64'(m_lat == 32'hFFFF_FFFF));
        chk("all_done",   64'(mon.all_done),   64'(m_all));
        chk("timeout",    64'(mon.timeout),    64'(m_tmo));
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        do w = 16'($urandom); while (w == ARM || w == STA || w == ENDM);
        return w;
    endfunction

    task automatic step(input logic [15:0] cb, input logic c);
`ifdef CHKMON_GOLDEN_CMP_EN
        logic r;
`endif
        mon.checkbits = cb;
        mon.clr = c;
        @(negedge clock);
`ifdef CHKMON_GOLDEN_CMP_EN
        r = mon.gold_ready;
`endif
        @(posedge clock);
        model_edge(cb, c);
        #1;
`ifdef CHKMON_GOLDEN_CMP_EN
        if (gold_on) begin
            if (r) gidx++;
            mon.gold_valid = (gidx < 64);
            mon.gold_data  = gold[(gidx < 64) ? gidx : 63];
        end
`endif
        check_all();
    endtask

    task automatic async_reset();
        resetb = 1'b0;
        mon.checkbits = 16'h0;
        mon.clr = 1'b0;
        #1;
        model_clear();
        check_all();
        @(posedge clock);
        #1;
        resetb = 1'b1;
    endtask

    initial begin
        int gaps [3];
        mon.checkbits = 16'h0;
        mon.clr = 1'b0;
`ifdef CHKMON_GOLDEN_CMP_EN
        mon.gold_data = 16'h0; mon.gold_valid = 1'b0; gold_on = 0; gidx = 0;
`endif
        m_cyc = 0;
        model_clear();
        @(posedge clock);
        #1;
        check_all();
        chk("rst_idx", 64'(mon.round_idx), 64'd0);
        resetb = 1'b1;

        // One round: START, nine fillers, END -> latency 10.
        step(ARM, 0);
        step(STA, 0);
        for (int i = 0; i < 9; i++) step(rnd_word(), 0);
        step(ENDM, 0);
        step(rnd_word(), 0);
        chk("t1_done", 64'(mon.round_done), 64'd1);
        chk("t1_lat",  64'(mon.latency),    64'd10);
        chk("t1_idx",  64'(mon.round_idx),  64'd1);
        chk("t1_busy", 64'(mon.busy),       64'd1);
        step(rnd_word(), 0);
        chk("t1_pulse", 64'(mon.round_done), 64'd0);

        // Three rounds with gaps 1, 64, 200.
        gaps = '{1, 64, 200};
        step(16'h0, 1);
        step(ARM, 0);
        for (int r = 0; r < 3; r++) begin
            step(STA, 0);
            for (int i = 0; i < gaps[r] - 1; i++) step(rnd_word(), 0);
            step(ENDM, 0);
            step(rnd_word(), 0);
            chk("t2_lat", 64'(mon.latency),   64'(gaps[r]));
            chk("t2_idx", 64'(mon.round_idx), 64'(r + 1));
        end
        chk("t2_all",  64'(mon.all_done), 64'd1);
        chk("t2_busy", 64'(mon.busy),     64'd0);

        // Markers out of order are ignored.
        step(16'h0, 1);
        step(STA, 0);
        step(ENDM, 0);
        step(rnd_word(), 0);
        step(rnd_word(), 0);
        chk("t3_idle", 64'(mon.busy), 64'd0);
        step(ARM, 0);
        step(ENDM, 0);
        step(ARM, 0);
        step(rnd_word(), 0);
        chk("t3_rd",   64'(mon.round_done), 64'd0);
        chk("t3_idx",  64'(mon.round_idx),  64'd0);
        chk("t3_busy", 64'(mon.busy),       64'd1);

        // Timeout at 500 cycles on the short-timeout instance.
        async_reset();
        step(ARM, 0);
        step(STA, 0);
        for (int i = 0; i < 497; i++) step(rnd_word(), 0);
        chk("t4_pre_tmo",  64'(mon_t.timeout), 64'd0);
        chk("t4_pre_busy", 64'(mon_t.busy),    64'd1);
        step(rnd_word(), 0);
        chk("t4_tmo",  64'(mon_t.timeout),    64'd1);
        chk("t4_busy", 64'(mon_t.busy),       64'd0);
        chk("t4_all",  64'(mon_t.all_done),   64'd0);
        chk("t4_rd",   64'(mon_t.round_done), 64'd0);

        // clr coincident with END wins.
        step(16'h0, 1);
        step(ARM, 0);
        step(STA, 0);
        step(rnd_word(), 0);
        step(ENDM, 0);
        step(rnd_word(), 1);
        chk("t5_rd",   64'(mon.round_done), 64'd0);
        chk("t5_idx",  64'(mon.round_idx),  64'd0);
        chk("t5_busy", 64'(mon.busy),       64'd0);
        step(rnd_word(), 0);
        chk("t5_rd2",  64'(mon.round_done), 64'd0);

        // Async reset mid-RUN after one completed round.
        step(ARM, 0);
        step(STA, 0);
        for (int i = 0; i < 3; i++) step(rnd_word(), 0);
        step(ENDM, 0);
        step(STA, 0);
        chk("t5_lat4", 64'(mon.latency), 64'd4);
        step(rnd_word(), 0);
        step(rnd_word(), 0);
        chk("t5_run", 64'(mon.busy), 64'd1);
        async_reset();
        chk("t5_rst_lat", 64'(mon.latency),   64'd0);
        chk("t5_rst_idx", 64'(mon.round_idx), 64'd0);

        // Random word stream with occasional clr.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [15:0] w;
            sel = int'($urandom_range(0, 99));
            if (sel < 15)      w = ARM;
            else if (sel < 30) w = STA;
            else if (sel < 45) w = ENDM;
            else               w = rnd_word();
            step(w, ($urandom_range(0, 99) == 0));
        end

`ifdef CHKMON_GOLDEN_CMP_EN
        // Golden compare: clean run then one corrupted index.
        for (int i = 0; i < 64; i++) gold[i] = {8'(i + 16), 8'($urandom)};
        for (int pass = 0; pass < 2; pass++) begin
            int bad;
            bad = (pass == 0) ? 64 : int'($urandom_range(1, 62));
            step(16'h0, 1);
            step(ARM, 0);
            step(STA, 0);
            gold_on = 1; gidx = 0;
            mon.gold_valid = 1'b1;
            mon.gold_data  = gold[0];
            for (int i = 0; i < 64; i++)
                step((i == bad) ? (gold[i] ^ 16'h0001) : gold[i], 0);
            step(ENDM, 0);
            step(rnd_word(), 0);
            chk("t6_match", 64'(mon.match_cnt), 64'((pass == 0) ? 64 : bad));
            gold_on = 0;
            mon.gold_valid = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
